qspis_wb_guard: RTL

- Registered Wishbone guard stage directly downstream of the QSPI slave's Wishbone master port, in front of the SoC interconnect.
- Forwards every single-beat classic-cycle request from the QSPI bridge and returns the downstream ack, error and read data.
- Aborts any request that receives no ack or error within TIMEOUT cycles and answers it upstream with an error.
- Keeps a sticky timeout flag, a saturating timeout counter and the address of the last timed-out request, so a bring-up host never hangs on a dead address.

---
 rtl/qspis_pkg.sv | 18 +
 rtl/qspis_wb_guard.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/qspis_pkg.sv
// Shared types and constants for the QSPI slave Wishbone guard stage.
package qspis_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 8;

    localparam logic [DAT_W-1:0] TMO_RDATA_DEF = 32'hDEAD_0BAD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/qspis_wb_guard.sv
// Registered Wishbone guard between the QSPI bridge and the interconnect:
// forwards single-beat requests, aborts unanswered ones and keeps timeout stats.
module qspis_wb_guard
    import qspis_pkg::*;
#(
    parameter int unsigned       TIMEOUT   = 255,
    parameter logic [DAT_W-1:0]  TMO_RDATA = TMO_RDATA_DEF
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             s_cyc_i,
    input  logic             s_stb_i,
    input  logic [ADR_W-1:0] s_adr_i,
    input  logic             s_we_i,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic [SEL_W-1:0] s_sel_i,
    output logic [DAT_W-1:0] s_dat_o,
    output logic             s_ack_o,
    output logic             s_err_o,
    output logic             m_cyc_o,
    output logic             m_stb_o,
    output logic [ADR_W-1:0] m_adr_o,
    output logic             m_we_o,
    output logic [DAT_W-1:0] m_dat_o,
    output logic [SEL_W-1:0] m_sel_o,
    input  logic [DAT_W-1:0] m_dat_i,
    input  logic             m_ack_i,
    input  logic             m_err_i,
    input  logic             clr_i,
    output logic             tmo_flag_o,
    output logic [CNT_W-1:0] tmo_cnt_o,
    output logic [ADR_W-1:0] tmo_adr_o
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   wait_q,     wait_d;
    logic               m_cyc_q,    m_cyc_d;
    logic               m_stb_q,    m_stb_d;
    logic [ADR_W-1:0]   m_adr_q,    m_adr_d;
    logic               m_we_q,     m_we_d;
    logic [DAT_W-1:0]   m_dat_q,    m_dat_d;
    logic [SEL_W-1:0]   m_sel_q,    m_sel_d;
    logic [DAT_W-1:0]   s_dat_q,    s_dat_d;
    logic               s_ack_q,    s_ack_d;
    logic               s_err_q,    s_err_d;
    logic               tmo_flag_q, tmo_flag_d;
    logic [CNT_W-1:0]   tmo_cnt_q,  tmo_cnt_d;
    logic [ADR_W-1:0]   tmo_adr_q,  tmo_adr_d;
    logic               tmo_evt;

    // Request FSM; downstream responses are only honoured while in REQ.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        m_cyc_d = m_cyc_q;
        m_stb_d = m_stb_q;
        m_adr_d = m_adr_q;
        m_we_d  = m_we_q;
        m_dat_d = m_dat_q;
        m_sel_d = m_sel_q;
        s_dat_d = s_dat_q;
        s_ack_d = 1'b0;
        s_err_d = 1'b0;
        tmo_evt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    m_adr_d = s_adr_i;
                    m_we_d  = s_we_i;
                    m_dat_d = s_dat_i;
                    m_sel_d = s_sel_i;
                    m_cyc_d = 1'b1;
                    m_stb_d = 1'b1;
                    wait_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (m_err_i) begin
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    s_err_d = 1'b1;
                    s_dat_d = m_dat_i;
                    state_d = ST_RESP;
                end else if (m_ack_i) begin
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    s_ack_d = 1'b1;
                    s_dat_d = m_dat_i;
                    state_d = ST_RESP;
                end else if (wait_q == WAIT_LAST) begin
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    s_err_d = 1'b1;
                    s_dat_d = TMO_RDATA;
                    tmo_evt = 1'b1;
                    state_d = ST_RESP;
                end else if (!s_cyc_i) begin
                    m_cyc_d = 1'b0;
                    m_stb_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = s_stb_i ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                // Swallow a strobe the upstream master drops late.
                if (!s_stb_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timeout statistics; a timeout in the same cycle as clr_i wins.
    always_comb begin
        tmo_flag_d = tmo_flag_q;
        tmo_cnt_d  = tmo_cnt_q;
        tmo_adr_d  = tmo_adr_q;
        if (tmo_evt) begin
            tmo_flag_d = 1'b1;
            tmo_adr_d  = m_adr_q;
            if (clr_i) begin
                tmo_cnt_d = CNT_W'(1);
            end else if (tmo_cnt_q != CNT_MAX) begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
        end else if (clr_i) begin
            tmo_flag_d = 1'b0;
            tmo_cnt_d  = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            m_cyc_q    <= 1'b0;
            m_stb_q    <= 1'b0;
            m_adr_q    <= '0;
            m_we_q     <= 1'b0;
            m_dat_q    <= '0;
            m_sel_q    <= '0;
            s_dat_q    <= '0;
            s_ack_q    <= 1'b0;
            s_err_q    <= 1'b0;
            tmo_flag_q <= 1'b0;
            tmo_cnt_q  <= '0;
            tmo_adr_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            m_cyc_q    <= m_cyc_d;
            m_stb_q    <= m_stb_d;
            m_adr_q    <= m_adr_d;
            m_we_q     <= m_we_d;
            m_dat_q    <= m_dat_d;
            m_sel_q    <= m_sel_d;
            s_dat_q    <= s_dat_d;
            s_ack_q    <= s_ack_d;
            s_err_q    <= s_err_d;
            tmo_flag_q <= tmo_flag_d;
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_adr_q  <= tmo_adr_d;
        end
    end

    assign s_dat_o    = s_dat_q;
    assign s_ack_o    = s_ack_q;
    assign s_err_o    = s_err_q;
    assign m_cyc_o    = m_cyc_q;
    assign m_stb_o    = m_stb_q;
    assign m_adr_o    = m_adr_q;
    assign m_we_o     = m_we_q;
    assign m_dat_o    = m_dat_q;
    assign m_sel_o    = m_sel_q;
    assign tmo_flag_o = tmo_flag_q;
    assign tmo_cnt_o  = tmo_cnt_q;
    assign tmo_adr_o  = tmo_adr_q;

endmodule
